// File: rtl/mips_seq_alu.sv
// Registered MIPS ALU with start/ready/done handshake and an iterative MULTU/DIVU unit.
// Define MIPS_SEQ_ALU_DIV_EN to include the DIVU datapath; otherwise code 4 is an unknown code.
module mips_seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       ALUctl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] ALUOut,
    output logic             Zero,
    output logic             Overflow,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [3:0] OP_AND   = 4'd0;
    localparam logic [3:0] OP_OR    = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_MULTU = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd6;
    localparam logic [3:0] OP_SLT   = 4'd7;
    localparam logic [3:0] OP_MFHI  = 4'd8;
    localparam logic [3:0] OP_MFLO  = 4'd9;
    localparam logic [3:0] OP_NOR   = 4'd12;
`ifdef MIPS_SEQ_ALU_DIV_EN
    localparam logic [3:0] OP_DIVU  = 4'd4;
`endif

    typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t           state_r, state_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic [WIDTH-1:0] acc_hi_r, acc_hi_s, acc_lo_r, acc_lo_s, opnd_r, opnd_s;
    logic [WIDTH-1:0] sum_s, diff_s, sc_res_s, sc_hi_s, sc_lo_s;
    logic             sc_ovf_s, iter_s;
    logic [WIDTH-1:0] res_s, hi_s, lo_s, step_hi_s, step_lo_s;
    logic             ovf_s, commit_s;
    logic [WIDTH:0]   mul_add_s;
`ifdef MIPS_SEQ_ALU_DIV_EN
    logic             is_div_r, is_div_s;
    logic [WIDTH:0]   div_shift_s, div_sub_s;
`endif

    assign ready = (state_r == IDLE);

    // Single-cycle result and classification of the requested operation.
    always_comb begin
        sum_s    = A + B;
        diff_s   = A - B;
        sc_res_s = {WIDTH{1'b0}};
        sc_ovf_s = 1'b0;
        sc_hi_s  = HI;
        sc_lo_s  = LO;
        iter_s   = 1'b0;
        case (ALUctl)
            OP_AND:   sc_res_s = A & B;
            OP_OR:    sc_res_s = A | B;
            OP_ADD: begin
                sc_res_s = sum_s;
                sc_ovf_s = (A[WIDTH-1] == B[WIDTH-1]) && (sum_s[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res_s = diff_s;
                sc_ovf_s = (A[WIDTH-1] != B[WIDTH-1]) && (diff_s[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SLT:   sc_res_s = ($signed(A) < $signed(B)) ? {{(WIDTH-1){1'b0}}, 1'b1} : {WIDTH{1'b0}};
            OP_NOR:   sc_res_s = ~(A | B);
            OP_MFHI:  sc_res_s = HI;
            OP_MFLO:  sc_res_s = LO;
            OP_MULTU: iter_s = 1'b1;
`ifdef MIPS_SEQ_ALU_DIV_EN
            OP_DIVU: begin
                if (B == {WIDTH{1'b0}}) begin
                    sc_res_s = {WIDTH{1'b1}};
                    sc_hi_s  = A;
                    sc_lo_s  = {WIDTH{1'b1}};
                end else begin
                    iter_s = 1'b1;
                end
            end
`endif
            default:  sc_res_s = {WIDTH{1'b0}};
        endcase
    end

    // One iteration: shift-add multiply, or restoring shift-subtract divide.
    always_comb begin
        mul_add_s = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
        step_hi_s = mul_add_s[WIDTH:1];
        step_lo_s = {mul_add_s[0], acc_lo_r[WIDTH-1:1]};
`ifdef MIPS_SEQ_ALU_DIV_EN
        div_shift_s = {acc_hi_r, acc_lo_r[WIDTH-1]};
        div_sub_s   = div_shift_s - {1'b0, opnd_r};
        if (is_div_r) begin
            // A clear borrow bit means the trial subtraction fits: keep it, quotient bit 1.
            if (!div_sub_s[WIDTH]) begin
                step_hi_s = div_sub_s[WIDTH-1:0];
                step_lo_s = {acc_lo_r[WIDTH-2:0], 1'b1};
            end else begin
                step_hi_s = div_shift_s[WIDTH-1:0];
                step_lo_s = {acc_lo_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_hi_s = mul_add_s[WIDTH:1];
            step_lo_s = {mul_add_s[0], acc_lo_r[WIDTH-1:1]};
        end
`endif
    end

    // Next-state, iteration bookkeeping and result commit selection.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        acc_hi_s = acc_hi_r;
        acc_lo_s = acc_lo_r;
        opnd_s   = opnd_r;
        commit_s = 1'b0;
        res_s    = ALUOut;
        hi_s     = HI;
        lo_s     = LO;
        ovf_s    = 1'b0;
`ifdef MIPS_SEQ_ALU_DIV_EN
        is_div_s = is_div_r;
`endif
        case (state_r)
            IDLE: begin
                if (start && iter_s) begin
                    state_s  = BUSY;
                    cnt_s    = CNT_INIT;
                    acc_hi_s = {WIDTH{1'b0}};
                    acc_lo_s = A;
                    opnd_s   = B;
`ifdef MIPS_SEQ_ALU_DIV_EN
                    is_div_s = (ALUctl == OP_DIVU);
`endif
                end else if (start) begin
                    commit_s = 1'b1;
                    res_s    = sc_res_s;
                    ovf_s    = sc_ovf_s;
                    hi_s     = sc_hi_s;
                    lo_s     = sc_lo_s;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                acc_hi_s = step_hi_s;
                acc_lo_s = step_lo_s;
                cnt_s    = cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    state_s  = IDLE;
                    commit_s = 1'b1;
                    res_s    = step_lo_s;
                    hi_s     = step_hi_s;
                    lo_s     = step_lo_s;
                end else begin
                    state_s = BUSY;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State, iteration and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            cnt_r    <= {CW{1'b0}};
            acc_hi_r <= {WIDTH{1'b0}};
            acc_lo_r <= {WIDTH{1'b0}};
            opnd_r   <= {WIDTH{1'b0}};
`ifdef MIPS_SEQ_ALU_DIV_EN
            is_div_r <= 1'b0;
`endif
            done     <= 1'b0;
            ALUOut   <= {WIDTH{1'b0}};
            Zero     <= 1'b1;
            Overflow <= 1'b0;
            HI       <= {WIDTH{1'b0}};
            LO       <= {WIDTH{1'b0}};
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            acc_hi_r <= acc_hi_s;
            acc_lo_r <= acc_lo_s;
            opnd_r   <= opnd_s;
`ifdef MIPS_SEQ_ALU_DIV_EN
            is_div_r <= is_div_s;
`endif
            done     <= commit_s;
            if (commit_s) begin
                ALUOut   <= res_s;
                Zero     <= (res_s == {WIDTH{1'b0}});
                Overflow <= ovf_s;
                HI       <= hi_s;
                LO       <= lo_s;
            end else begin
                ALUOut   <= ALUOut;
                Zero     <= Zero;
                Overflow <= Overflow;
                HI       <= HI;
                LO       <= LO;
            end
        end
    end
endmodule

// File: tb/tb_mips_seq_alu.sv
// Self-checking bench for mips_seq_alu (WIDTH=32) against a behavioural arithmetic model.
module tb_mips_seq_alu;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  ALUctl = 4'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        ready, done, Zero, Overflow;
    logic [31:0] ALUOut, HI, LO;

    int total = 0;
    int bad = 0;
    logic [31:0] mhi = 32'd0;
    logic [31:0] mlo = 32'd0;

    mips_seq_alu #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .ALUctl(ALUctl), .A(A), .B(B),
        .ready(ready), .done(done), .ALUOut(ALUOut), .Zero(Zero), .Overflow(Overflow),
        .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    // Reference model: expected result/overflow/latency; updates model HI/LO.
    task automatic predict(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output logic ovf, output int lat);
        longint sa, sb, s;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        res = 32'd0; ovf = 1'b0; lat = 0;
        case (op)
            4'd0: res = a & b;
            4'd1: res = a | b;
            4'd2: begin s = sa + sb; res = s[31:0]; ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'd6: begin s = sa - sb; res = s[31:0]; ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'd7: res = (sa < sb) ? 32'd1 : 32'd0;
            4'd12: res = ~(a | b);
            4'd3: begin p = 64'(a) * 64'(b); mhi = p[63:32]; mlo = p[31:0]; res = mlo; lat = 32; end
`ifdef MIPS_SEQ_ALU_DIV_EN
            4'd4: begin
                if (b == 32'd0) begin mlo = 32'hFFFFFFFF; mhi = a; res = mlo; end
                else begin mlo = a / b; mhi = a % b; res = mlo; lat = 32; end
            end
`endif
            4'd8: res = mhi;
            4'd9: res = mlo;
            default: res = 32'd0;
        endcase
    endtask

    // Issue one operation (called #1 after an edge with ready high); returns cycles until done.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int cycles);
        ALUctl = op; A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cycles = 0;
        while (done !== 1'b1 && cycles < 100) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", ready); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b exp=0", done); end
        total++; if (ALUOut !== 32'd0 || HI !== 32'd0 || LO !== 32'd0) begin
            bad++; $display("FAIL reset_regs aluout=%h hi=%h lo=%h exp=0", ALUOut, HI, LO); end
        total++; if (Zero !== 1'b1 || Overflow !== 1'b0) begin
            bad++; $display("FAIL reset_flags zero=%0b ovf=%0b exp zero=1 ovf=0", Zero, Overflow); end
        reset = 1'b0;
        mhi = 32'd0; mlo = 32'd0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [3:0]  codes [6] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12};
        logic [31:0] exps  [6] = '{32'd32, 32'd118, 32'd150, 32'd50, 32'd0, 32'hFFFFFF89};
        A = 32'd100; B = 32'd50; ALUctl = codes[0]; start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            total++; if (ready !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d] got=%0b exp=1", i, ready); end
            @(posedge clk); #1;
            total++; if (done !== 1'b1 || ALUOut !== exps[i]) begin
                bad++; $display("FAIL b2b_result[%0d] done=%0b got=%h exp=%h", i, done, ALUOut, exps[i]); end
            total++; if (Zero !== (exps[i] == 32'd0)) begin
                bad++; $display("FAIL b2b_zero[%0d] got=%0b exp=%0b", i, Zero, exps[i] == 32'd0); end
            if (i < 5) ALUctl = codes[i+1];
            else start = 1'b0;
        end
        @(posedge clk); #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL b2b_done_drop got=%0b exp=0", done); end
    endtask

    task automatic test_overflow();
        int cyc;
        do_op(4'd2, 32'h7FFFFFFF, 32'd1, cyc);
        total++; if (cyc != 0 || ALUOut !== 32'h80000000 || Overflow !== 1'b1) begin
            bad++; $display("FAIL add_ovf cyc=%0d got=%h ovf=%0b exp=80000000 ovf=1", cyc, ALUOut, Overflow); end
        do_op(4'd6, 32'h80000000, 32'd1, cyc);
        total++; if (cyc != 0 || ALUOut !== 32'h7FFFFFFF || Overflow !== 1'b1) begin
            bad++; $display("FAIL sub_ovf cyc=%0d got=%h ovf=%0b exp=7fffffff ovf=1", cyc, ALUOut, Overflow); end
        do_op(4'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc);
        total++; if (Overflow !== 1'b0) begin bad++; $display("FAIL and_no_ovf got=%0b exp=0", Overflow); end
    endtask

    task automatic test_multu();
        int cyc, ready_bad;
        logic [31:0] r; logic o; int lat;
        predict(4'd3, 32'hFFFFFFFF, 32'd2, r, o, lat);
        ALUctl = 4'd3; A = 32'hFFFFFFFF; B = 32'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; cyc = 0; ready_bad = 0;
        while (done !== 1'b1 && cyc < 100) begin
            if (ready !== 1'b0) ready_bad++;
            if (cyc == 5) begin ALUctl = 4'd2; A = 32'd3; B = 32'd4; start = 1'b1; end
            else start = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        total++; if (cyc != 32) begin bad++; $display("FAIL multu_latency got=%0d exp=32", cyc); end
        total++; if (ready_bad != 0) begin bad++; $display("FAIL multu_ready_low bad_cycles=%0d exp=0", ready_bad); end
        total++; if (HI !== 32'd1 || LO !== 32'hFFFFFFFE || ALUOut !== 32'hFFFFFFFE || ready !== 1'b1) begin
            bad++; $display("FAIL multu_result hi=%h lo=%h out=%h rdy=%0b exp 1/fffffffe/fffffffe/1", HI, LO, ALUOut, ready); end
        @(posedge clk); #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL multu_ignored_start done=%0b exp=0", done); end
        predict(4'd8, 32'd0, 32'd0, r, o, lat);
        do_op(4'd8, 32'd0, 32'd0, cyc);
        total++; if (cyc != 0 || ALUOut !== 32'd1) begin bad++; $display("FAIL mfhi cyc=%0d got=%h exp=1", cyc, ALUOut); end
    endtask

    task automatic test_divu();
        int cyc;
        logic [31:0] r, hi0, lo0; logic o; int lat;
        hi0 = mhi; lo0 = mlo;
        predict(4'd4, 32'd100, 32'd7, r, o, lat);
        do_op(4'd4, 32'd100, 32'd7, cyc);
`ifdef MIPS_SEQ_ALU_DIV_EN
        total++; if (cyc != 32 || LO !== 32'd14 || HI !== 32'd2 || ALUOut !== 32'd14) begin
            bad++; $display("FAIL divu cyc=%0d lo=%h hi=%h exp 32/e/2", cyc, LO, HI); end
`else
        total++; if (cyc != 0 || ALUOut !== 32'd0 || Zero !== 1'b1 || HI !== hi0 || LO !== lo0) begin
            bad++; $display("FAIL divu_off cyc=%0d out=%h zero=%0b hi=%h lo=%h exp 0/0/1/%h/%h", cyc, ALUOut, Zero, HI, LO, hi0, lo0); end
`endif
        hi0 = mhi; lo0 = mlo;
        predict(4'd4, 32'd100, 32'd0, r, o, lat);
        do_op(4'd4, 32'd100, 32'd0, cyc);
`ifdef MIPS_SEQ_ALU_DIV_EN
        total++; if (cyc != 0 || LO !== 32'hFFFFFFFF || HI !== 32'd100 || ALUOut !== 32'hFFFFFFFF) begin
            bad++; $display("FAIL divu_by0 cyc=%0d lo=%h hi=%h exp 0/ffffffff/64", cyc, LO, HI); end
`else
        total++; if (cyc != 0 || ALUOut !== 32'd0 || Zero !== 1'b1 || HI !== hi0 || LO !== lo0) begin
            bad++; $display("FAIL divu_by0_off cyc=%0d out=%h hi=%h lo=%h exp 0/0/%h/%h", cyc, ALUOut, HI, LO, hi0, lo0); end
`endif
    endtask

    task automatic test_random();
        logic [31:0] corner [5] = '{32'd0, 32'd1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};
        logic [31:0] a, b, r; logic o; logic [3:0] op; int lat, cyc;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 32'($urandom_range(0, 1000));
            if ($urandom_range(0, 1) == 1) b = $urandom;
            predict(op, a, b, r, o, lat);
            total++; if (ready !== 1'b1) begin bad++; $display("FAIL rnd_ready[%0d] got=%0b exp=1", i, ready); end
            do_op(op, a, b, cyc);
            total++; if (cyc != lat) begin bad++; $display("FAIL rnd_latency[%0d] op=%0d got=%0d exp=%0d", i, op, cyc, lat); end
            total++; if (ALUOut !== r || Zero !== (r == 32'd0) || Overflow !== o) begin
                bad++; $display("FAIL rnd_result[%0d] op=%0d a=%h b=%h got=%h/%0b/%0b exp=%h/%0b/%0b",
                                i, op, a, b, ALUOut, Zero, Overflow, r, r == 32'd0, o); end
            total++; if (HI !== mhi || LO !== mlo) begin
                bad++; $display("FAIL rnd_hilo[%0d] op=%0d got=%h/%h exp=%h/%h", i, op, HI, LO, mhi, mlo); end
        end
    endtask

    task automatic test_reset_mid_busy();
        int cyc;
        ALUctl = 4'd3; A = 32'hFFFFFFFF; B = 32'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        total++; if (ready !== 1'b1 || done !== 1'b0) begin
            bad++; $display("FAIL midreset_hs ready=%0b done=%0b exp 1/0", ready, done); end
        total++; if (ALUOut !== 32'd0 || HI !== 32'd0 || LO !== 32'd0 || Zero !== 1'b1) begin
            bad++; $display("FAIL midreset_regs out=%h hi=%h lo=%h zero=%0b exp 0/0/0/1", ALUOut, HI, LO, Zero); end
        @(posedge clk); #1;
        reset = 1'b0;
        mhi = 32'd0; mlo = 32'd0;
        @(posedge clk); #1;
        do_op(4'd2, 32'd3, 32'd4, cyc);
        total++; if (cyc != 0 || ALUOut !== 32'd7) begin bad++; $display("FAIL midreset_add cyc=%0d got=%h exp=7", cyc, ALUOut); end
        @(posedge clk); #1;
        total++; if (done !== 1'b0 || HI !== 32'd0) begin
            bad++; $display("FAIL midreset_trace done=%0b hi=%h exp 0/0", done, HI); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_overflow();
        test_multu();
        test_divu();
        test_random();
        test_reset_mid_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mips_seq_alu.md
# mips_seq_alu

Parametrised, clocked MIPS ALU for the multi-cycle datapath. It keeps the existing ALUctl encodings for AND/OR/ADD/SUB/SLT/NOR, registers every result, and adds a start/ready/done handshake. It also adds an iterative unsigned multiply/divide unit with HI/LO registers, plus overflow reporting. It sits between the register-file read stage and the ALUOut register, and the control FSM stalls on `ready`.

## Interface
- `WIDTH`, default 32: datapath width; must be ≥ 4.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high; clears all state.
- `start` in 1: operation request; accepted on a rising edge when `start && ready`.
- `ALUctl` in 4: operation code; sampled on acceptance.
- `A`, `B` in WIDTH: operands; sampled on acceptance.
- `ready` out 1: high in IDLE; combinational from state.
- `done` out 1: one-cycle pulse when `ALUOut`/`Zero`/`Overflow` update.
- `ALUOut` out WIDTH: registered result; held until the next `done`.
- `Zero` out 1: registered `ALUOut == 0`.
- `Overflow` out 1: signed overflow for ADD/SUB; 0 for all other codes.
- `HI`, `LO` out WIDTH: multiply/divide result registers.

## Operation
- Codes:
  - 0 AND, 1 OR, 2 ADD, 6 SUB (two's complement, wraps modulo 2^WIDTH).
  - 7 SLT (signed A<B → 1, else 0).
  - 12 NOR.
  - 3 MULTU: {HI,LO} = A*B unsigned, 2·WIDTH bits; ALUOut = LO.
  - 4 DIVU: LO = A/B, HI = A%B unsigned; ALUOut = LO.
  - 8 MFHI: ALUOut = HI. 9 MFLO: ALUOut = LO.
  - Any other code: ALUOut = 0, Zero = 1, Overflow = 0, HI/LO unchanged.
- States:
  - IDLE: `ready = 1`.
    - Single-cycle code accepted → stay in IDLE; results register at the accepting edge.
    - MULTU, or DIVU with B≠0 → go to BUSY with iteration counter = WIDTH.
  - BUSY: `ready = 0`; one shift-add (MULTU) or restoring shift-subtract (DIVU) step per cycle; counter decrements.
    - When the counter reaches 0, write HI/LO/ALUOut/Zero, pulse `done`, return to IDLE.
- DIVU with B = 0 is single-cycle: LO = all ones, HI = A, ALUOut = all ones.
- `start` while `ready = 0` is ignored; no queueing. `ALUctl`/`A`/`B` may change freely during BUSY.
- HI/LO change only on MULTU/DIVU completion. MFHI/MFLO read the committed values.
- Overflow:
  - ADD: A and B have the same sign and the sign of ALUOut differs.
  - SUB: A and B have different signs and the sign of ALUOut differs from A.
- Reset, including mid-BUSY: state = IDLE; `ALUOut`, `HI`, `LO`, `Overflow`, `done` = 0; `Zero` = 1; `ready` = 1. The aborted operation leaves no trace.

## Timing
- Acceptance edge N.
- Single-cycle ops:
  - Outputs valid and `done = 1` in the cycle after edge N.
  - Back-to-back acceptance every cycle; `ready` never drops.
- Iterative ops:
  - `ready` low from edge N until edge N+WIDTH.
  - Results and `done` appear after edge N+WIDTH, so latency is WIDTH cycles.
  - `ready` is high in the same cycle as `done`, and `start` in that cycle is accepted.
- `done` is never high for two consecutive cycles from one operation. Consecutive single-cycle ops give a continuous `done` stream, one pulse per operation.

## Configuration
- `MIPS_SEQ_ALU_DIV_EN` defined: code 4 DIVU implemented as above.
- `MIPS_SEQ_ALU_DIV_EN` undefined:
  - The divider datapath is omitted.
  - Code 4 is treated as an unknown code: single-cycle, ALUOut = 0, Zero = 1, HI/LO unchanged.
  - MULTU is unaffected.

## Test plan
- WIDTH=32, A=100, B=50, codes 0,1,2,6,7,12 issued back to back:
  - ALUOut = 32, 118, 150, 50, 0 (Zero=1), 0xFFFFFF89 on consecutive `done` cycles.
  - `ready` stays 1 throughout.
- ADD with A=0x7FFFFFFF, B=1 → ALUOut = 0x80000000, Overflow = 1.
- SUB with A=0x80000000, B=1 → ALUOut = 0x7FFFFFFF, Overflow = 1.
- MULTU with A=0xFFFFFFFF, B=2:
  - `ready` low for 32 cycles; a `start` pulse during BUSY is ignored.
  - `done` after 32 cycles with HI = 1, LO = ALUOut = 0xFFFFFFFE.
  - A following MFHI returns 1.
- DIVU (macro on) with A=100, B=7 → after 32 cycles LO = 14, HI = 2.
- DIVU with A=100, B=0 → next cycle LO = 0xFFFFFFFF, HI = 100.
- DIVU with the macro off → next cycle ALUOut = 0, Zero = 1, HI/LO unchanged.
- Reset asserted 10 cycles into a MULTU:
  - Immediately `ready = 1`, `done = 0`, ALUOut/HI/LO = 0, Zero = 1.
  - After release, ADD with A=3, B=4 → ALUOut = 7 next cycle.
